// File: rtl/ws281x_pkg.sv
// Shared constants for the WS281x receive path.
// Widths of the word and pulse counters, plus the receive FSM state codes.
package ws281x_pkg;

    localparam int WS_BITS = 24;
    localparam int CNT_HW  = 10;
    localparam int CNT_LW  = 16;

    localparam logic [1:0] RST_WAIT = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] HIGH     = 2'd2;
    localparam logic [1:0] LOW      = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a show-ahead head word.
// A pop and a push in the same cycle both succeed, even when full.
module sync_fifo #(
    parameter int W = 24,
    parameter int D = 2
) (
    input  logic         mclk,
    input  logic         h_reset_n,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rd,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(D);
    localparam logic [AW:0] DEPTH = (AW+1)'(D);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_rd;
    logic          do_wr;

    assign full  = (cnt == DEPTH);
    assign empty = (cnt == '0);
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign dout  = empty ? '0 : mem[rp];

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

    always_ff @(posedge mclk) begin
        if (do_wr) mem[wp] <= din;
    end

endmodule

// File: rtl/ws281x_rx_sync.sv
// Synchronizes the asynchronous WS281x line and derives edge strobes.
module ws281x_rx_sync #(
    parameter int SW = 2
) (
    input  logic mclk,
    input  logic h_reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SW-1:0] sr;
    logic          prev;

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            sr   <= '0;
            prev <= 1'b0;
        end else begin
            sr   <= {sr[SW-2:0], din};
            prev <= sr[SW-1];
        end
    end

    assign level = sr[SW-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/ws281x_rx.sv
// WS281x NRZ receiver: measures high pulses, decodes bits MSB first,
// and queues 24-bit words with frame-end and error reporting.
module ws281x_rx
    import ws281x_pkg::*;
#(
    parameter int FD = 2,
    parameter int SW = 2
) (
    input  logic                 mclk,
    input  logic                 h_reset_n,
    input  logic                 cfg_enb,
    input  logic [CNT_LW-1:0]    cfg_reset_period,
    input  logic [CNT_HW-1:0]    cfg_bit_thresh,
    input  logic [CNT_HW-1:0]    cfg_min_high,
    input  logic                 sts_clr,
    input  logic                 ws_din,
    input  logic                 rx_rd,
    output logic [WS_BITS-1:0]   rx_data,
    output logic                 rx_dval,
    output logic                 rx_frame_done,
    output logic                 sts_overflow,
    output logic                 sts_frame_err,
    output logic                 sts_glitch
);

    localparam logic [4:0] LAST_BIT = 5'(WS_BITS - 1);

    logic                 level;
    logic                 rise;
    logic                 fall;
    logic [1:0]           state;
    logic [CNT_HW-1:0]    hi_cnt;
    logic [CNT_LW-1:0]    lo_cnt;
    logic [CNT_LW-1:0]    rst_per;
    logic [4:0]           bit_cnt;
    logic [WS_BITS-1:0]   shift;
    logic                 wr_pend;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_ok;
    logic                 bit_val;
    logic                 glitch_set;
    logic                 frame_end;
    logic                 ferr_set;
    logic                 ovf_set;

    ws281x_rx_sync #(.SW(SW)) u_sync (
        .mclk      (mclk),
        .h_reset_n (h_reset_n),
        .din       (ws_din),
        .level     (level),
        .rise      (rise),
        .fall      (fall)
    );

    sync_fifo #(.W(WS_BITS), .D(FD)) u_fifo (
        .mclk      (mclk),
        .h_reset_n (h_reset_n),
        .wr        (wr_pend),
        .din       (shift),
        .rd        (rx_rd),
        .dout      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_dval    = ~fifo_empty;
    assign rst_per    = (cfg_reset_period == '0) ? 16'd1 : cfg_reset_period;
    assign bit_ok     = (hi_cnt >= cfg_min_high);
    assign bit_val    = (hi_cnt >= cfg_bit_thresh);
    assign glitch_set = cfg_enb & (state == HIGH) & fall & ~bit_ok;
    assign frame_end  = cfg_enb & (state == LOW) & ~rise & (lo_cnt == rst_per);
    assign ferr_set   = frame_end & (bit_cnt != '0);
    assign ovf_set    = wr_pend & fifo_full & ~rx_rd;

    // hi_cnt reads N at the fall of an N-cycle pulse; lo_cnt counts the fall cycle as 1
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            if (rise)
                hi_cnt <= 10'd1;
            else if (level && hi_cnt != '1)
                hi_cnt <= hi_cnt + 1'b1;
            if (rise)
                lo_cnt <= '0;
            else if (fall)
                lo_cnt <= 16'd1;
            else if (!level && lo_cnt != '1)
                lo_cnt <= lo_cnt + 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            state   <= RST_WAIT;
            bit_cnt <= '0;
            shift   <= '0;
            wr_pend <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (!cfg_enb) begin
                state   <= RST_WAIT;
                bit_cnt <= '0;
                shift   <= '0;
            end else begin
                unique case (state)
                    RST_WAIT: begin
                        if (!level && lo_cnt >= rst_per) state <= IDLE;
                    end
                    IDLE: begin
                        if (rise) state <= HIGH;
                    end
                    HIGH: begin
                        if (fall && !bit_ok) begin
                            state   <= RST_WAIT;
                            bit_cnt <= '0;
                            shift   <= '0;
                        end else if (fall) begin
                            state <= LOW;
                            shift <= {shift[WS_BITS-2:0], bit_val};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                wr_pend <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            state <= HIGH;
                        end else if (lo_cnt == rst_per) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end
                    end
                    default: state <= RST_WAIT;
                endcase
            end
        end
    end

    // set beats a simultaneous clear
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            rx_frame_done <= 1'b0;
            sts_overflow  <= 1'b0;
            sts_frame_err <= 1'b0;
            sts_glitch    <= 1'b0;
        end else begin
            rx_frame_done <= frame_end;
            sts_overflow  <= (sts_overflow  & ~sts_clr) | ovf_set;
            sts_frame_err <= (sts_frame_err & ~sts_clr) | ferr_set;
            sts_glitch    <= (sts_glitch    & ~sts_clr) | glitch_set;
        end
    end

endmodule

// File: tb/tb_ws281x_rx.sv
// Self-checking bench for ws281x_rx against a pulse-width reference model.
module tb_ws281x_rx;

    logic        mclk = 1'b0;
    logic        h_reset_n = 1'b0;
    logic        cfg_enb = 1'b0;
    logic [15:0] cfg_reset_period = 16'd2500;
    logic [9:0]  cfg_bit_thresh = 10'd31;
    logic [9:0]  cfg_min_high = 10'd5;
    logic        sts_clr = 1'b0;
    logic        ws_din = 1'b0;
    logic        rx_rd = 1'b0;
    logic [23:0] rx_data;
    logic        rx_dval;
    logic        rx_frame_done;
    logic        sts_overflow;
    logic        sts_frame_err;
    logic        sts_glitch;

    ws281x_rx #(.FD(2), .SW(2)) dut (
        .mclk             (mclk),
        .h_reset_n        (h_reset_n),
        .cfg_enb          (cfg_enb),
        .cfg_reset_period (cfg_reset_period),
        .cfg_bit_thresh   (cfg_bit_thresh),
        .cfg_min_high     (cfg_min_high),
        .sts_clr          (sts_clr),
        .ws_din           (ws_din),
        .rx_rd            (rx_rd),
        .rx_data          (rx_data),
        .rx_dval          (rx_dval),
        .rx_frame_done    (rx_frame_done),
        .sts_overflow     (sts_overflow),
        .sts_frame_err    (sts_frame_err),
        .sts_glitch       (sts_glitch)
    );

    always #5 mclk = ~mclk;

    int fd_cnt = 0;
    always @(negedge mclk) if (rx_frame_done === 1'b1) fd_cnt++;

    int          passed = 0;
    int          total = 0;
    int          wq[$];
    logic [23:0] exp_q[$];
    bit          exp_ovf = 0;
    bit          exp_ferr = 0;
    bit          exp_glitch = 0;
    int          exp_fd = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // one 62-cycle bit slot with a high pulse of hi cycles
    task automatic pulse(int hi);
        @(negedge mclk) ws_din = 1'b1;
        repeat (hi) @(negedge mclk);
        ws_din = 1'b0;
        repeat (61 - hi) @(negedge mclk);
    endtask

    task automatic mk_word(logic [23:0] w, int w0, int w1);
        for (int i = 23; i >= 0; i--) wq.push_back(w[i] ? w1 : w0);
    endtask

    task automatic mk_rand(int nbits);
        for (int i = 0; i < nbits; i++) wq.push_back(int'($urandom_range(55, 5)));
    endtask

    // drive queued pulses plus a reset gap; the model decodes widths by rule
    task automatic frame();
        int          nb = 0;
        bit          dead = 0;
        logic [23:0] sh = '0;
        foreach (wq[i]) begin
            pulse(wq[i]);
            if (!dead) begin
                if (wq[i] < int'(cfg_min_high)) begin
                    exp_glitch = 1;
                    dead = 1;
                end else begin
                    sh = {sh[22:0], (wq[i] >= int'(cfg_bit_thresh))};
                    nb++;
                    if (nb == 24) begin
                        nb = 0;
                        if (exp_q.size() < 2) exp_q.push_back(sh);
                        else exp_ovf = 1;
                    end
                end
            end
        end
        repeat (2520) @(negedge mclk);
        if (!dead && wq.size() > 0) begin
            exp_fd++;
            if (nb != 0) exp_ferr = 1;
        end
        wq.delete();
    endtask

    task automatic check_frame(string tag);
        chk({tag, "_dval"}, {31'd0, rx_dval}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) chk({tag, "_head"}, {8'd0, rx_data}, {8'd0, exp_q[0]});
        chk({tag, "_ovf"}, {31'd0, sts_overflow}, {31'd0, exp_ovf});
        chk({tag, "_ferr"}, {31'd0, sts_frame_err}, {31'd0, exp_ferr});
        chk({tag, "_glitch"}, {31'd0, sts_glitch}, {31'd0, exp_glitch});
        chk({tag, "_fdone"}, fd_cnt, exp_fd);
    endtask

    task automatic drain(string tag);
        while (exp_q.size() != 0) begin
            chk({tag, "_pop"}, {8'd0, rx_data}, {8'd0, exp_q[0]});
            @(negedge mclk) rx_rd = 1'b1;
            @(negedge mclk) rx_rd = 1'b0;
            void'(exp_q.pop_front());
        end
        chk({tag, "_empty"}, {31'd0, rx_dval}, 32'd0);
    endtask

    task automatic clear_sts();
        @(negedge mclk) sts_clr = 1'b1;
        @(negedge mclk) sts_clr = 1'b0;
        exp_ovf = 0;
        exp_ferr = 0;
        exp_glitch = 0;
    endtask

    initial begin
        repeat (3) @(negedge mclk);
        chk("rst_dval", {31'd0, rx_dval}, 32'd0);
        chk("rst_data", {8'd0, rx_data}, 32'd0);
        chk("rst_fdone", {31'd0, rx_frame_done}, 32'd0);
        chk("rst_ovf", {31'd0, sts_overflow}, 32'd0);
        chk("rst_ferr", {31'd0, sts_frame_err}, 32'd0);
        chk("rst_glitch", {31'd0, sts_glitch}, 32'd0);
        h_reset_n = 1'b1;
        cfg_enb = 1'b1;
        repeat (2600) @(negedge mclk);

        mk_word(24'hA5C30F, 20, 40);
        frame();
        check_frame("basic");
        chk("basic_word", {8'd0, rx_data}, 32'h00A5C30F);
        drain("basic");

        mk_word(24'h5A3C96, 30, 31);
        frame();
        check_frame("thresh");
        chk("thresh_word", {8'd0, rx_data}, 32'h005A3C96);
        drain("thresh");

        for (int k = 0; k < 3; k++) begin
            mk_rand(24);
            frame();
            check_frame("rand");
            drain("rand");
        end

        mk_rand(24);
        frame();
        repeat (8) pulse(40);
        @(negedge mclk) cfg_enb = 1'b0;
        repeat (5) @(negedge mclk);
        cfg_enb = 1'b1;
        repeat (2600) @(negedge mclk);
        check_frame("enb_drop");
        drain("enb_drop");

        mk_rand(72);
        frame();
        check_frame("ovf");
        drain("ovf");
        clear_sts();
        chk("ovf_clr", {31'd0, sts_overflow}, 32'd0);

        mk_rand(12);
        frame();
        check_frame("partial");
        clear_sts();
        chk("partial_clr", {31'd0, sts_frame_err}, 32'd0);

        mk_word(24'h3C0FF0, 20, 40);
        wq[8] = 3;
        frame();
        check_frame("glitch");
        mk_rand(24);
        frame();
        check_frame("post_glitch");
        drain("post_glitch");

        repeat (10) pulse(40);
        @(negedge mclk) h_reset_n = 1'b0;
        exp_q.delete();
        exp_ovf = 0;
        exp_ferr = 0;
        exp_glitch = 0;
        repeat (2) @(negedge mclk);
        chk("mid_rst_dval", {31'd0, rx_dval}, 32'd0);
        chk("mid_rst_data", {8'd0, rx_data}, 32'd0);
        chk("mid_rst_glitch", {31'd0, sts_glitch}, 32'd0);
        chk("mid_rst_fdone", {31'd0, rx_frame_done}, 32'd0);
        h_reset_n = 1'b1;
        repeat (2600) @(negedge mclk);
        mk_rand(24);
        frame();
        check_frame("post_rst");
        drain("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
